modport_apb_slave: RTL and testbench
====================================

# modport_apb_slave

APB slave register bank for the electric-oven controller. Terminates the APB bus that the verification environment's DRIVER/MONITOR modports sit on. Holds a small array of software-visible 32-bit registers: general read/write registers plus one read-only ID word. Always completes transfers with zero wait states.

## Interface
- ADDR_WIDTH, 8: width of paddr.
- DATA_WIDTH, 32: width of pwdata/prdata and of every register.
- NUM_REGS, 16: number of decoded words. Indices 0..NUM_REGS-2 are read/write; index NUM_REGS-1 is read-only ID. Must be a power of two, ≥2, ≤2^ADDR_WIDTH.
- ID_VALUE, 32'h0EE0_0001: constant returned by the ID register.

Ports:
- clk, input, 1: single clock; all state updates on its rising edge.
- reset, input, 1: synchronous, active-low reset (0 = reset asserted, sampled on posedge clk).
- paddr, input, ADDR_WIDTH: word index (no byte addressing).
- psel, input, 1: slave select.
- penable, input, 1: access phase.
- pwrite, input, 1: 1 = write, 0 = read.
- pwdata, input, DATA_WIDTH: write data.
- pready, output, 1: transfer complete.
- prdata, output, DATA_WIDTH: read data.

## Operation
- Decode: idx = paddr[$clog2(NUM_REGS)-1:0]. The address is in range when paddr < NUM_REGS. Upper address bits must be zero; otherwise the access is out of range.
- Write: when reset=1, psel=1, penable=1, pwrite=1, pready=1 and the address is in range with idx ≠ NUM_REGS-1, then reg[idx] <= pwdata at the clock edge.
- Ignored writes: writes to the ID index or out of range are accepted (pready still 1) and change nothing.
- Read: prdata is combinational.
  - prdata = reg[idx] when psel=1, pwrite=0 and the address is in range.
  - prdata = ID_VALUE at the ID index.
  - prdata = 0 out of range, and 0 whenever psel=0 or pwrite=1.
  - Read data is therefore valid in the setup phase (psel=1, penable=0) and stays stable through the access phase.
- pready = psel & penable & reset. It is combinational, with no wait states. It is high exactly during the access cycle, drops with psel/penable, and is never high for two consecutive cycles of a legal APB master.
- Reset (reset=0 at posedge): all RW registers cleared to 0. While reset=0, pready is forced to 0 and no write takes effect.
- A transfer in flight when reset asserts is abandoned. After release the master must restart with a fresh setup phase.
- No error response: there is no pslverr.

## Timing
- Write latency: register updates at the posedge that ends the access cycle. A read issued next, with setup at cycle N+1, returns the new value combinationally in that setup cycle.
- Read latency: 0 cycles from paddr/psel valid to prdata valid. The full transfer is 2 cycles (setup, access).
- Back-to-back transfers: psel may stay high. Every transfer needs a new setup cycle with penable=0.
- psel=1 with penable=0 never writes.
- penable=1 with psel=0 is ignored.
- A write and a read of the same register cannot coincide (single port).

## Structure
- Shared package `oven_apb_pkg`:
  - ADDR_WIDTH/DATA_WIDTH defaults and the NUM_REGS default.
  - ID_VALUE.
  - Named register indices: REG_CTRL=0, REG_TARGET_TEMP=1, REG_TIMER=2, REG_ID=NUM_REGS-1.
  - APB phase enum: IDLE/SETUP/ACCESS, used by the bench monitor.
- No FSM is needed in RTL; phase is implied by psel/penable.
- One natural sub-module: `apb_reg_file`, the NUM_REGS×DATA_WIDTH storage with write port and combinational read mux. The top handles decode and pready.

## Test plan
- Reset: hold reset=0 for 2 cycles, release, read idx 0..14 → each prdata=0. Read idx 15 → 32'h0EE0_0001. pready=0 throughout the reset cycles.
- Write/readback: write 32'h0000_00B4 to idx 1 (setup then access), then read idx 1. Require prdata=32'h0000_00B4 already in the setup cycle, and pready=1 only in each access cycle.
- Read-only and out-of-range:
  - write 32'hDEAD_BEEF to idx 15 → reads 32'h0EE0_0001;
  - write to paddr=8'h20 → pready=1, no register changes;
  - read paddr=8'h20 → 0.
- Back-to-back: psel held high, writes to idx 0,1,2 with values 1,2,3 then reads of idx 0,1,2 → 1,2,3. pready pulses one cycle per transfer and falls when psel falls.
- Reset mid-transfer: setup a write of 32'h55 to idx 2, assert reset=0 on the access cycle → pready=0, and after release idx 2 reads 0.
- Setup-only phase: psel=1, pwrite=1, penable=0 held 3 cycles with pwdata=32'hFF on idx 3 → idx 3 still reads 0.

Source files
------------

// File: rtl/oven_apb_pkg.sv
// Shared definitions for the oven controller APB register bank and its bench.
package oven_apb_pkg;

    // Default bus and register-array geometry.
    localparam int unsigned ADDR_WIDTH = 8;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned NUM_REGS   = 16;

    // Constant returned by the read-only identification word.
    localparam logic [31:0] ID_VALUE = 32'h0EE0_0001;

    // Named register indices (word addresses).
    localparam int unsigned REG_CTRL        = 0;
    localparam int unsigned REG_TARGET_TEMP = 1;
    localparam int unsigned REG_TIMER       = 2;
    localparam int unsigned REG_ID          = NUM_REGS - 1;

    // APB transfer phase as seen on psel/penable.
    typedef enum logic [1:0] {
        PhaseIdle,
        PhaseSetup,
        PhaseAccess
    } apb_phase_e;

    // Classify the current bus cycle; penable without psel is not a transfer.
    function automatic apb_phase_e apb_phase(input logic psel, input logic penable);
        if (!psel) begin
            return PhaseIdle;
        end else if (!penable) begin
            return PhaseSetup;
        end else begin
            return PhaseAccess;
        end
    endfunction

endpackage

// File: rtl/apb_reg_file.sv
// Register storage: NumRegs words, one write port, combinational read mux.
// The top word is a constant ID and is never stored.
module apb_reg_file
    import oven_apb_pkg::*;
#(
    parameter int unsigned           DataWidth = oven_apb_pkg::DATA_WIDTH,
    parameter int unsigned           NumRegs   = oven_apb_pkg::NUM_REGS,
    parameter logic [DataWidth-1:0]  IdValue   = DataWidth'(oven_apb_pkg::ID_VALUE),
    localparam int unsigned          IdxW      = $clog2(NumRegs)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,   // synchronous, active low
    input  logic                 we_i,
    input  logic [IdxW-1:0]      waddr_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic [IdxW-1:0]      raddr_i,
    output logic [DataWidth-1:0] rdata_o
);

    localparam logic [IdxW-1:0] IdIdx = IdxW'(NumRegs - 1);

    // Only the writable words hold state.
    logic [DataWidth-1:0] regs_q [NumRegs-1];
    logic [DataWidth-1:0] regs_d [NumRegs-1];

    // Next state: update the addressed word; the ID slot is silently skipped.
    always_comb begin
        for (int unsigned i = 0; i < NumRegs - 1; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (we_i && (waddr_i != IdIdx)) begin
            for (int unsigned i = 0; i < NumRegs - 1; i++) begin
                if (waddr_i == IdxW'(i)) begin
                    regs_d[i] = wdata_i;
                end
            end
        end
    end

    // State register with synchronous clear.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NumRegs - 1; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NumRegs - 1; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read mux: ID constant at the top index, stored word elsewhere.
    always_comb begin
        rdata_o = IdValue;
        for (int unsigned i = 0; i < NumRegs - 1; i++) begin
            if (raddr_i == IdxW'(i)) begin
                rdata_o = regs_q[i];
            end
        end
    end

endmodule

// File: rtl/modport_apb_slave.sv
// Zero-wait-state APB slave for the oven controller register bank.
// Handles address decode, pready and read gating; storage lives in apb_reg_file.
module modport_apb_slave
    import oven_apb_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH = oven_apb_pkg::ADDR_WIDTH,
    parameter int unsigned            DATA_WIDTH = oven_apb_pkg::DATA_WIDTH,
    parameter int unsigned            NUM_REGS   = oven_apb_pkg::NUM_REGS,
    parameter logic [DATA_WIDTH-1:0]  ID_VALUE   = DATA_WIDTH'(oven_apb_pkg::ID_VALUE)
) (
    input  logic                  clk,
    input  logic                  reset,    // synchronous, active low
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic                  pready,
    output logic [DATA_WIDTH-1:0] prdata
);

    localparam int unsigned IdxW = $clog2(NUM_REGS);

    logic [IdxW-1:0]       idx;
    logic                  in_range;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] rf_rdata;

    // Decode: low bits pick the word; the extra leading zero lets
    // NUM_REGS == 2**ADDR_WIDTH compare without truncating to zero.
    always_comb begin
        idx      = paddr[IdxW-1:0];
        in_range = ({1'b0, paddr} < (ADDR_WIDTH + 1)'(NUM_REGS));
    end

    // Handshake and read gating: no wait states, reads only while selected.
    always_comb begin
        pready = psel & penable & reset;
        wr_en  = pready & pwrite & in_range;
        prdata = '0;
        if (psel && !pwrite && in_range) begin
            prdata = rf_rdata;
        end
    end

    apb_reg_file #(
        .DataWidth (DATA_WIDTH),
        .NumRegs   (NUM_REGS),
        .IdValue   (ID_VALUE)
    ) u_reg_file (
        .clk_i   (clk),
        .rst_ni  (reset),
        .we_i    (wr_en),
        .waddr_i (idx),
        .wdata_i (pwdata),
        .raddr_i (idx),
        .rdata_o (rf_rdata)
    );

endmodule

// File: tb/tb_modport_apb_slave.sv
// Self-checking bench for modport_apb_slave: vector table plus hand-written corner sequences.
module tb_modport_apb_slave;
    import oven_apb_pkg::*;

    logic        clk;
    logic        reset;
    logic [7:0]  paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic        pready;
    logic [31:0] prdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] sb_q [$];

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
        logic        idle_after;
    } vec_t;

    vec_t vecs [$];

    modport_apb_slave dut (
        .clk     (clk),
        .reset   (reset),
        .paddr   (paddr),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .pwdata  (pwdata),
        .pready  (pready),
        .prdata  (prdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus monitor: pready must only appear in an access phase and never twice in a row.
    int         bad_pready = 0;
    logic       pready_prev = 1'b0;
    apb_phase_e phase;
    always @(negedge clk) begin
        phase = apb_phase(psel, penable);
        if (pready && (phase != PhaseAccess || pready_prev)) bad_pready <= bad_pready + 1;
        pready_prev <= pready;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One transfer: setup cycle then access cycle; psel stays high afterwards.
    task automatic xfer(input logic wr, input logic [7:0] a, input logic [31:0] d,
                        input logic [31:0] exp, input string name);
        logic [31:0] want;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        if (!wr) sb_q.push_back(exp);
        @(negedge clk);
        check({name, "_setup_pready"}, {31'd0, pready}, 32'd0);
        check({name, "_setup_prdata"}, prdata, wr ? 32'd0 : exp);
        next_cycle();
        penable = 1'b1;
        @(negedge clk);
        check({name, "_access_pready"}, {31'd0, pready}, 32'd1);
        if (!wr) begin
            if (sb_q.size() == 0) begin
                check({name, "_sb_empty"}, 32'd1, 32'd0);
            end else begin
                want = sb_q.pop_front();
                check({name, "_access_prdata"}, prdata, want);
            end
        end
        next_cycle();
    endtask

    task automatic go_idle(input string name);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        @(negedge clk);
        check({name, "_idle_pready"}, {31'd0, pready}, 32'd0);
        check({name, "_idle_prdata"}, prdata, 32'd0);
        next_cycle();
    endtask

    function automatic vec_t mk(input logic wr, input logic [7:0] a, input logic [31:0] d,
                                input logic [31:0] e, input logic idle);
        vec_t v;
        v.wr = wr; v.addr = a; v.data = d; v.exp = e; v.idle_after = idle;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held for two cycles with an access-phase write on the bus: must not land.
        reset = 1'b0; psel = 1'b1; penable = 1'b1; pwrite = 1'b1;
        paddr = 8'd4; pwdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check($sformatf("reset_pready%0d", i), {31'd0, pready}, 32'd0);
            next_cycle();
        end
        reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        next_cycle();

        // Reset values, then write/readback, read-only and out-of-range cases.
        for (int i = 0; i < 15; i++) vecs.push_back(mk(1'b0, 8'(i), 32'd0, 32'd0, 1'b1));
        vecs.push_back(mk(1'b0, 8'd15, 32'd0, 32'h0EE0_0001, 1'b1));
        vecs.push_back(mk(1'b1, 8'd1,  32'h0000_00B4, 32'd0, 1'b1));
        vecs.push_back(mk(1'b0, 8'd1,  32'd0, 32'h0000_00B4, 1'b1));
        vecs.push_back(mk(1'b1, 8'd15, 32'hDEAD_BEEF, 32'd0, 1'b1));
        vecs.push_back(mk(1'b0, 8'd15, 32'd0, 32'h0EE0_0001, 1'b1));
        vecs.push_back(mk(1'b1, 8'h20, 32'h1234_5678, 32'd0, 1'b1));
        vecs.push_back(mk(1'b0, 8'h20, 32'd0, 32'd0, 1'b1));
        vecs.push_back(mk(1'b1, 8'h10, 32'hAAAA_5555, 32'd0, 1'b1));
        vecs.push_back(mk(1'b0, 8'h10, 32'd0, 32'd0, 1'b1));
        vecs.push_back(mk(1'b0, 8'd0,  32'd0, 32'd0, 1'b1));
        vecs.push_back(mk(1'b0, 8'd1,  32'd0, 32'h0000_00B4, 1'b1));
        // Back-to-back with psel held high.
        vecs.push_back(mk(1'b1, 8'd0, 32'd1, 32'd0, 1'b0));
        vecs.push_back(mk(1'b1, 8'd1, 32'd2, 32'd0, 1'b0));
        vecs.push_back(mk(1'b1, 8'd2, 32'd3, 32'd0, 1'b0));
        vecs.push_back(mk(1'b0, 8'd0, 32'd0, 32'd1, 1'b0));
        vecs.push_back(mk(1'b0, 8'd1, 32'd0, 32'd2, 1'b0));
        vecs.push_back(mk(1'b0, 8'd2, 32'd0, 32'd3, 1'b1));

        for (int i = 0; i < vecs.size(); i++) begin
            xfer(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].exp, $sformatf("vec%0d", i));
            if (vecs[i].idle_after) go_idle($sformatf("vec%0d", i));
        end

        // Reset asserted in the access cycle abandons the write and clears the bank.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd2; pwdata = 32'h55;
        next_cycle();
        penable = 1'b1; reset = 1'b0;
        @(negedge clk);
        check("midreset_pready", {31'd0, pready}, 32'd0);
        next_cycle();
        reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        next_cycle();
        xfer(1'b0, 8'd2, 32'd0, 32'd0, "midreset_idx2");
        go_idle("midreset_idx2");
        xfer(1'b0, 8'd1, 32'd0, 32'd0, "midreset_idx1");
        go_idle("midreset_idx1");

        // Setup phase held for three cycles must never write.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd3; pwdata = 32'hFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("setup_only_pready%0d", i), {31'd0, pready}, 32'd0);
            next_cycle();
        end
        // penable without psel is not a transfer.
        psel = 1'b0; penable = 1'b1;
        @(negedge clk);
        check("penable_only_pready", {31'd0, pready}, 32'd0);
        next_cycle();
        penable = 1'b0;
        next_cycle();
        xfer(1'b0, 8'd3, 32'd0, 32'd0, "setup_only_idx3");
        go_idle("setup_only_idx3");

        check("pready_protocol", 32'(bad_pready), 32'd0);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
